// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit.
package lsu_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        WAIT,
        RESP
    } lsu_state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_D  = 3'b011;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    localparam logic [2:0] F3_WU = 3'b110;

    // Byte-enable pattern for an access of the given size, before lane shifting.
    function automatic logic [7:0] size_mask(input logic [2:0] funct3);
        case (funct3)
            F3_B, F3_BU: return 8'h01;
            F3_H, F3_HU: return 8'h03;
            F3_W, F3_WU: return 8'h0F;
            F3_D:        return 8'hFF;
            default:     return 8'h00;
        endcase
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering: store shift and byte enables, load extraction and extension.
module lsu_align
    import lsu_pkg::*;
#(
    parameter  int DATA_W = 32,
    localparam int STRB_W = DATA_W / 8,
    localparam int OFF_W  = $clog2(STRB_W)
) (
    input  logic [2:0]        funct3,
    input  logic [OFF_W-1:0]  off,
    input  logic [DATA_W-1:0] wdata,
    input  logic [DATA_W-1:0] rdata,
    output logic [STRB_W-1:0] be,
    output logic [DATA_W-1:0] wdata_sh,
    output logic [DATA_W-1:0] rdata_ext
);

    logic [DATA_W-1:0] shifted;

    assign be       = STRB_W'(size_mask(funct3)) << off;
    assign wdata_sh = wdata << {off, 3'b000};
    assign shifted  = rdata >> {off, 3'b000};

    // Sized casts of signed slices give sign extension without zero-width replications.
    always_comb begin
        rdata_ext = shifted;
        case (funct3)
            F3_B:    rdata_ext = DATA_W'($signed(shifted[7:0]));
            F3_BU:   rdata_ext = DATA_W'(shifted[7:0]);
            F3_H:    rdata_ext = DATA_W'($signed(shifted[15:0]));
            F3_HU:   rdata_ext = DATA_W'(shifted[15:0]);
            F3_W:    rdata_ext = DATA_W'($signed(shifted[31:0]));
            F3_WU:   rdata_ext = DATA_W'(shifted[31:0]);
            default: rdata_ext = shifted;
        endcase
    end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store unit controller between the MEM stage and a fixed-latency data memory.
module lsu_ctrl
    import lsu_pkg::*;
#(
    parameter  int DATA_W  = 32,
    parameter  int ADDR_W  = 9,
    parameter  int MEM_LAT = 2,
    localparam int STRB_W  = DATA_W / 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              stall,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              err,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [STRB_W-1:0] mem_be,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int OFF_W = $clog2(STRB_W);
    localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MEM_LAT - 1);

    lsu_state_t        state_q, state_d;
    logic              we_q, err_q, legal, accept;
    logic [2:0]        funct3_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q, rdata_q, rdata_ext;
    logic [STRB_W-1:0] be_al;
    logic [CNT_W-1:0]  cnt_q;

    assign accept = (state_q == IDLE) && req_valid;

    always_comb begin
        legal = 1'b0;
        case (req_funct3)
            F3_B, F3_BU: legal = 1'b1;
            F3_H, F3_HU: legal = (req_addr[0] == 1'b0);
            F3_W:        legal = (req_addr[1:0] == 2'b00);
            F3_WU:       legal = (DATA_W == 64) && (req_addr[1:0] == 2'b00);
            F3_D:        legal = (DATA_W == 64) && (req_addr[2:0] == 3'b000);
            default:     legal = 1'b0;
        endcase
        if (req_we && req_funct3[2]) legal = 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Stall is masked by reset so every output is low while reset is held.
    always_comb begin
        state_d    = state_q;
        stall      = 1'b0;
        resp_valid = 1'b0;
        mem_rd     = 1'b0;
        mem_wr     = 1'b0;
        mem_be     = '0;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    stall   = ~reset;
                    state_d = legal ? ACCESS : RESP;
                end
            end
            ACCESS: begin
                stall   = 1'b1;
                mem_rd  = ~we_q;
                mem_wr  = we_q;
                mem_be  = be_al;
                state_d = we_q ? RESP : WAIT;
            end
            WAIT: begin
                stall = 1'b1;
                if (cnt_q == '0) state_d = RESP;
            end
            RESP: begin
                resp_valid = 1'b1;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Address and store data only move for legal requests so the memory bus is undisturbed by errors.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            we_q     <= 1'b0;
            err_q    <= 1'b0;
            funct3_q <= 3'b000;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            cnt_q    <= '0;
        end else begin
            if (accept) begin
                we_q     <= req_we;
                err_q    <= ~legal;
                funct3_q <= req_funct3;
                rdata_q  <= '0;
                if (legal) begin
                    addr_q  <= req_addr;
                    wdata_q <= req_wdata;
                end
            end
            if (state_q == ACCESS) begin
                cnt_q <= CNT_INIT;
            end else if (state_q == WAIT) begin
                if (cnt_q == '0) rdata_q <= rdata_ext;
                else             cnt_q   <= cnt_q - 1'b1;
            end
        end
    end

    lsu_align #(.DATA_W(DATA_W)) u_align (
        .funct3    (funct3_q),
        .off       (addr_q[OFF_W-1:0]),
        .wdata     (wdata_q),
        .rdata     (mem_rdata),
        .be        (be_al),
        .wdata_sh  (mem_wdata),
        .rdata_ext (rdata_ext)
    );

    assign mem_addr   = {addr_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
    assign resp_rdata = resp_valid ? rdata_q : '0;
    assign err        = resp_valid & err_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed bench for lsu_ctrl: a 32-bit/MEM_LAT=2 and a 64-bit/MEM_LAT=1 instance side by side.
module tb_lsu_ctrl;
    import lsu_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic reset;

    logic        req_valid_32, req_we_32, stall_32, resp_valid_32, err_32, mem_rd_32, mem_wr_32;
    logic [2:0]  req_funct3_32;
    logic [8:0]  req_addr_32, mem_addr_32;
    logic [31:0] req_wdata_32, resp_rdata_32, mem_wdata_32, mem_rdata_32;
    logic [3:0]  mem_be_32;

    logic        req_valid_64, req_we_64, stall_64, resp_valid_64, err_64, mem_rd_64, mem_wr_64;
    logic [2:0]  req_funct3_64;
    logic [8:0]  req_addr_64, mem_addr_64;
    logic [63:0] req_wdata_64, resp_rdata_64, mem_wdata_64, mem_rdata_64;
    logic [7:0]  mem_be_64;

    lsu_ctrl #(.DATA_W(32), .ADDR_W(9), .MEM_LAT(2)) u_dut32 (
        .clk(clk), .reset(reset), .req_valid(req_valid_32), .req_we(req_we_32),
        .req_funct3(req_funct3_32), .req_addr(req_addr_32), .req_wdata(req_wdata_32),
        .stall(stall_32), .resp_valid(resp_valid_32), .resp_rdata(resp_rdata_32), .err(err_32),
        .mem_rd(mem_rd_32), .mem_wr(mem_wr_32), .mem_addr(mem_addr_32), .mem_be(mem_be_32),
        .mem_wdata(mem_wdata_32), .mem_rdata(mem_rdata_32)
    );

    lsu_ctrl #(.DATA_W(64), .ADDR_W(9), .MEM_LAT(1)) u_dut64 (
        .clk(clk), .reset(reset), .req_valid(req_valid_64), .req_we(req_we_64),
        .req_funct3(req_funct3_64), .req_addr(req_addr_64), .req_wdata(req_wdata_64),
        .stall(stall_64), .resp_valid(resp_valid_64), .resp_rdata(resp_rdata_64), .err(err_64),
        .mem_rd(mem_rd_64), .mem_wr(mem_wr_64), .mem_addr(mem_addr_64), .mem_be(mem_be_64),
        .mem_wdata(mem_wdata_64), .mem_rdata(mem_rdata_64)
    );

    // Unified view of whichever instance the current transaction targets.
    logic        sel64;
    logic        o_stall, o_resp_valid, o_err, o_mem_rd, o_mem_wr;
    logic [63:0] o_resp_rdata, o_mem_wdata;
    logic [7:0]  o_mem_be;
    logic [8:0]  o_mem_addr;

    assign o_stall      = sel64 ? stall_64      : stall_32;
    assign o_resp_valid = sel64 ? resp_valid_64 : resp_valid_32;
    assign o_err        = sel64 ? err_64        : err_32;
    assign o_mem_rd     = sel64 ? mem_rd_64     : mem_rd_32;
    assign o_mem_wr     = sel64 ? mem_wr_64     : mem_wr_32;
    assign o_resp_rdata = sel64 ? resp_rdata_64 : {32'h0, resp_rdata_32};
    assign o_mem_wdata  = sel64 ? mem_wdata_64  : {32'h0, mem_wdata_32};
    assign o_mem_be     = sel64 ? mem_be_64     : {4'h0, mem_be_32};
    assign o_mem_addr   = sel64 ? mem_addr_64   : mem_addr_32;

    typedef struct {
        bit        is64;
        bit        we;
        bit [2:0]  f3;
        bit [8:0]  addr;
        bit [63:0] wdata;
        bit [63:0] rdata;
        bit        exp_err;
        bit [63:0] exp_rdata;
        bit [7:0]  exp_be;
        bit [8:0]  exp_maddr;
        bit [63:0] exp_wdata;
        int        exp_lat;
    } vec_t;

    vec_t vecs[$];
    int   n_checks;
    int   n_fail;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t v, input bit valid);
        if (v.is64) begin
            req_valid_64  = valid;
            req_we_64     = v.we;
            req_funct3_64 = v.f3;
            req_addr_64   = v.addr;
            req_wdata_64  = v.wdata;
        end else begin
            req_valid_32  = valid;
            req_we_32     = v.we;
            req_funct3_32 = v.f3;
            req_addr_32   = v.addr;
            req_wdata_32  = v.wdata[31:0];
        end
    endtask

    task automatic setMemData(input vec_t v, input bit good);
        if (v.is64) mem_rdata_64 = good ? v.rdata : ~v.rdata;
        else        mem_rdata_32 = good ? v.rdata[31:0] : ~v.rdata[31:0];
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_ctl32"}, 64'({stall_32, resp_valid_32, err_32, mem_rd_32, mem_wr_32, mem_be_32}), 64'h0);
        checkOutput({tag, "_bus32"}, {23'h0, mem_addr_32, mem_wdata_32}, 64'h0);
        checkOutput({tag, "_rdata32"}, 64'(resp_rdata_32), 64'h0);
        checkOutput({tag, "_ctl64"}, 64'({stall_64, resp_valid_64, err_64, mem_rd_64, mem_wr_64, mem_be_64}), 64'h0);
        checkOutput({tag, "_addr64"}, 64'(mem_addr_64), 64'h0);
        checkOutput({tag, "_wdata64"}, mem_wdata_64, 64'h0);
        checkOutput({tag, "_rdata64"}, resp_rdata_64, 64'h0);
    endtask

    // One complete transaction with req_valid held until the response, memory data valid only in its window.
    task automatic runTxn(input vec_t v, input int idx);
        int          lat, acc_cyc, resp_cyc, n_acc, n_resp, stall_bad, be_bad;
        bit          done, got_rd;
        logic        got_err;
        logic [7:0]  got_be;
        logic [8:0]  got_addr;
        logic [63:0] got_wdata, got_rdata;
        string       p;
        p = $sformatf("v%0d", idx);
        lat = v.is64 ? 1 : 2;
        acc_cyc = -1; resp_cyc = -1; n_acc = 0; n_resp = 0; stall_bad = 0; be_bad = 0;
        done = 1'b0; got_rd = 1'b0; got_err = 1'b0; got_be = '0; got_addr = '0;
        got_wdata = '0; got_rdata = '0;
        sel64 = v.is64;
        @(posedge clk); #1;
        applyStimulus(v, 1'b1);
        setMemData(v, 1'b0);
        for (int c = 0; c < 16 && !done; c++) begin
            @(negedge clk);
            if (o_mem_rd || o_mem_wr) begin
                n_acc++;
                if (acc_cyc < 0) begin
                    acc_cyc = c; got_rd = o_mem_rd; got_be = o_mem_be;
                    got_addr = o_mem_addr; got_wdata = o_mem_wdata;
                end
            end else if (o_mem_be != 8'h0) begin
                be_bad++;
            end
            if (o_resp_valid) begin
                n_resp++; resp_cyc = c; got_err = o_err; got_rdata = o_resp_rdata; done = 1'b1;
                if (o_stall) stall_bad++;
            end else if (!o_stall) begin
                stall_bad++;
            end
            @(posedge clk); #1;
            if (done) applyStimulus(v, 1'b0);
            setMemData(v, (acc_cyc >= 0) && (c + 1 == acc_cyc + lat));
        end
        @(negedge clk);
        checkOutput({p, "_after"}, 64'({o_resp_valid, o_stall, o_mem_rd, o_mem_wr}), 64'h0);
        checkOutput({p, "_lat"}, 64'(resp_cyc), 64'(v.exp_lat));
        checkOutput({p, "_nresp"}, 64'(n_resp), 64'd1);
        checkOutput({p, "_err"}, 64'(got_err), 64'(v.exp_err));
        checkOutput({p, "_rdata"}, got_rdata, v.exp_rdata);
        checkOutput({p, "_naccess"}, 64'(n_acc), v.exp_err ? 64'd0 : 64'd1);
        checkOutput({p, "_stall"}, 64'(stall_bad), 64'd0);
        checkOutput({p, "_be_idle"}, 64'(be_bad), 64'd0);
        if (!v.exp_err) begin
            checkOutput({p, "_acc_cyc"}, 64'(acc_cyc), 64'd1);
            checkOutput({p, "_rd_not_wr"}, 64'(got_rd), 64'(!v.we));
            checkOutput({p, "_maddr"}, 64'(got_addr), 64'(v.exp_maddr));
            checkOutput({p, "_be"}, 64'(got_be), 64'(v.exp_be));
            if (v.we) checkOutput({p, "_wdata"}, got_wdata, v.exp_wdata);
        end
    endtask

    // Two loads with req_valid never dropping: the second is presented right after the first RESP.
    task automatic backToBack();
        vec_t        a, b;
        int          resp_at[2], rd_at[2];
        logic [63:0] rdv[2];
        int          nr, nrd;
        bit          saw;
        a = '{1'b0, 1'b0, F3_W,  9'h000, 64'h0, 64'h11223344, 1'b0, 64'h0, 8'h0, 9'h0, 64'h0, 0};
        b = '{1'b0, 1'b0, F3_BU, 9'h002, 64'h0, 64'h11223344, 1'b0, 64'h0, 8'h0, 9'h0, 64'h0, 0};
        resp_at = '{-1, -1}; rd_at = '{-1, -1}; rdv = '{64'h0, 64'h0};
        nr = 0; nrd = 0;
        sel64 = 1'b0;
        @(posedge clk); #1;
        mem_rdata_32 = 32'h11223344;
        applyStimulus(a, 1'b1);
        for (int c = 0; c < 14; c++) begin
            @(negedge clk);
            saw = o_resp_valid;
            if (o_mem_rd) begin
                if (nrd < 2) rd_at[nrd] = c;
                nrd++;
            end
            if (o_resp_valid) begin
                if (nr < 2) begin resp_at[nr] = c; rdv[nr] = o_resp_rdata; end
                nr++;
            end
            @(posedge clk); #1;
            if (saw && nr == 1) applyStimulus(b, 1'b1);
            else if (saw)       applyStimulus(b, 1'b0);
        end
        checkOutput("b2b_nresp", 64'(nr), 64'd2);
        checkOutput("b2b_nrd", 64'(nrd), 64'd2);
        checkOutput("b2b_resp0", 64'(resp_at[0]), 64'd4);
        checkOutput("b2b_resp1", 64'(resp_at[1]), 64'd9);
        checkOutput("b2b_rd1", 64'(rd_at[1]), 64'd6);
        checkOutput("b2b_data0", rdv[0], 64'h11223344);
        checkOutput("b2b_data1", rdv[1], 64'h22);
    endtask

    task automatic resetInWait();
        vec_t ld, st;
        int   stale;
        ld = '{1'b0, 1'b0, F3_W, 9'h008, 64'h0, 64'h55AA55AA, 1'b0, 64'h0, 8'h0, 9'h0, 64'h0, 0};
        st = '{1'b0, 1'b1, F3_W, 9'h004, 64'hA5A5A5A5, 64'h0, 1'b0, 64'h0, 8'h0F, 9'h004, 64'hA5A5A5A5, 2};
        stale = 0;
        sel64 = 1'b0;
        @(posedge clk); #1;
        applyStimulus(ld, 1'b1);
        mem_rdata_32 = 32'h55AA55AA;
        @(posedge clk); #1;
        @(posedge clk); #2;
        reset = 1'b1;
        applyStimulus(ld, 1'b0);
        #1;
        checkAllZero("rst_wait");
        @(posedge clk); @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (resp_valid_32 || stall_32 || mem_rd_32) stale++;
        end
        checkOutput("rst_wait_stale", 64'(stale), 64'd0);
        runTxn(st, 99);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        n_checks = 0; n_fail = 0; sel64 = 1'b0;
        req_valid_32 = 1'b0; req_we_32 = 1'b0; req_funct3_32 = 3'b0; req_addr_32 = '0;
        req_wdata_32 = '0; mem_rdata_32 = '0;
        req_valid_64 = 1'b0; req_we_64 = 1'b0; req_funct3_64 = 3'b0; req_addr_64 = '0;
        req_wdata_64 = '0; mem_rdata_64 = '0;
        reset = 1'b1;
        #12;
        checkAllZero("reset");
        @(negedge clk); @(negedge clk);
        reset = 1'b0;

        // is64 we f3 addr wdata rdata | err rdata be maddr wdata lat
        vecs.push_back('{1'b0, 1'b0, F3_B,   9'h003, 64'h0, 64'h80FF1234, 1'b0, 64'hFFFFFF80, 8'h08, 9'h000, 64'h0, 4});
        vecs.push_back('{1'b0, 1'b1, F3_H,   9'h006, 64'h0000BEEF, 64'h0, 1'b0, 64'h0, 8'h0C, 9'h004, 64'hBEEF0000, 2});
        vecs.push_back('{1'b0, 1'b0, F3_W,   9'h005, 64'h0, 64'h12345678, 1'b1, 64'h0, 8'h00, 9'h000, 64'h0, 1});
        vecs.push_back('{1'b0, 1'b0, F3_BU,  9'h001, 64'h0, 64'h1234F678, 1'b0, 64'h000000F6, 8'h02, 9'h000, 64'h0, 4});
        vecs.push_back('{1'b0, 1'b0, F3_H,   9'h002, 64'h0, 64'h80010000, 1'b0, 64'hFFFF8001, 8'h0C, 9'h000, 64'h0, 4});
        vecs.push_back('{1'b0, 1'b0, F3_HU,  9'h002, 64'h0, 64'h80010000, 1'b0, 64'h00008001, 8'h0C, 9'h000, 64'h0, 4});
        vecs.push_back('{1'b0, 1'b0, F3_W,   9'h008, 64'h0, 64'hCAFEBABE, 1'b0, 64'hCAFEBABE, 8'h0F, 9'h008, 64'h0, 4});
        vecs.push_back('{1'b0, 1'b1, F3_B,   9'h00D, 64'h000000A5, 64'h0, 1'b0, 64'h0, 8'h02, 9'h00C, 64'h0000A500, 2});
        vecs.push_back('{1'b0, 1'b1, F3_W,   9'h010, 64'h12345678, 64'h0, 1'b0, 64'h0, 8'h0F, 9'h010, 64'h12345678, 2});
        vecs.push_back('{1'b0, 1'b0, F3_H,   9'h003, 64'h0, 64'h0, 1'b1, 64'h0, 8'h00, 9'h000, 64'h0, 1});
        vecs.push_back('{1'b0, 1'b0, F3_D,   9'h000, 64'h0, 64'h0, 1'b1, 64'h0, 8'h00, 9'h000, 64'h0, 1});
        vecs.push_back('{1'b0, 1'b1, F3_BU,  9'h000, 64'h0, 64'h0, 1'b1, 64'h0, 8'h00, 9'h000, 64'h0, 1});
        vecs.push_back('{1'b0, 1'b0, F3_WU,  9'h000, 64'h0, 64'h0, 1'b1, 64'h0, 8'h00, 9'h000, 64'h0, 1});
        vecs.push_back('{1'b0, 1'b0, 3'b111, 9'h000, 64'h0, 64'h0, 1'b1, 64'h0, 8'h00, 9'h000, 64'h0, 1});
        vecs.push_back('{1'b0, 1'b1, F3_B,   9'h1FF, 64'h0000005A, 64'h0, 1'b0, 64'h0, 8'h08, 9'h1FC, 64'h5A000000, 2});
        vecs.push_back('{1'b0, 1'b1, F3_H,   9'h001, 64'h00001234, 64'h0, 1'b1, 64'h0, 8'h00, 9'h000, 64'h0, 1});
        vecs.push_back('{1'b1, 1'b0, F3_WU,  9'h00C, 64'h0, 64'h8765432100000000, 1'b0, 64'h0000000087654321, 8'hF0, 9'h008, 64'h0, 3});
        vecs.push_back('{1'b1, 1'b0, F3_D,   9'h00C, 64'h0, 64'h0, 1'b1, 64'h0, 8'h00, 9'h000, 64'h0, 1});
        vecs.push_back('{1'b1, 1'b0, F3_D,   9'h010, 64'h0, 64'hFEDCBA9876543210, 1'b0, 64'hFEDCBA9876543210, 8'hFF, 9'h010, 64'h0, 3});
        vecs.push_back('{1'b1, 1'b0, F3_W,   9'h00C, 64'h0, 64'h8765432100000000, 1'b0, 64'hFFFFFFFF87654321, 8'hF0, 9'h008, 64'h0, 3});
        vecs.push_back('{1'b1, 1'b1, F3_D,   9'h018, 64'h0123456789ABCDEF, 64'h0, 1'b0, 64'h0, 8'hFF, 9'h018, 64'h0123456789ABCDEF, 2});
        vecs.push_back('{1'b1, 1'b1, F3_W,   9'h01C, 64'hFFFFFFFFDEADBEEF, 64'h0, 1'b0, 64'h0, 8'hF0, 9'h018, 64'hDEADBEEF00000000, 2});
        vecs.push_back('{1'b1, 1'b0, F3_B,   9'h007, 64'h0, 64'h7F00000000000000, 1'b0, 64'h7F, 8'h80, 9'h000, 64'h0, 3});
        vecs.push_back('{1'b1, 1'b0, F3_HU,  9'h006, 64'h0, 64'h8001000000000000, 1'b0, 64'h8001, 8'hC0, 9'h000, 64'h0, 3});
        vecs.push_back('{1'b1, 1'b1, F3_D,   9'h01C, 64'h1, 64'h0, 1'b1, 64'h0, 8'h00, 9'h000, 64'h0, 1});

        foreach (vecs[i]) runTxn(vecs[i], i);
        backToBack();
        resetInWait();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
